// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I immediate encoder/decoder pair.
package instr_encoder_pkg;

    // Immediate format selector; 0, 1 and 7 all select the I format.
    typedef enum logic [2:0] {
        IMM_TYPE_I   = 3'd0,
        IMM_TYPE_I2  = 3'd1,
        IMM_TYPE_S   = 3'd2,
        IMM_TYPE_B   = 3'd3,
        IMM_TYPE_U   = 3'd4,
        IMM_TYPE_J   = 3'd5,
        IMM_TYPE_CSR = 3'd6,
        IMM_TYPE_I3  = 3'd7
    } imm_type_e;

    // Buffered entry is {range error, packed instruction}.
    localparam int unsigned FIFO_W = 33;

    // True when v is representable as a signed value of 'bits' bits,
    // i.e. v[31:bits-1] are all equal.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = $signed(v) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding packed words; the read port holds the last
// popped entry while empty.
module instr_fifo
    import instr_encoder_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_W,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && (count != CW'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign pop_data = (count == '0) ? last_q : mem[rd_ptr];

    // Pointer, occupancy and last-popped bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array write port; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs RV32I instruction fields into a 32-bit word, range-checks the
// immediate per format and queues the result for a valid/ready sink.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [2:0]       imm_type_in,
    input  logic [6:0]       opcode_in,
    input  logic [4:0]       rd_in,
    input  logic [2:0]       funct3_in,
    input  logic [4:0]       rs1_in,
    input  logic [4:0]       rs2_in,
    input  logic [6:0]       funct7_in,
    input  logic [31:0]      imm_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [31:0]      instr_out,
    output logic             imm_err_out,
    output logic             err_sticky_out,
    input  logic             clr_in,
    output logic [CNT_W-1:0] word_count_out
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    imm_type_e         imm_type;
    logic [31:0]       packed_word;
    logic              range_err;
    logic              accept;
    logic              pop;
    logic [FIFO_W-1:0] fifo_out;
    logic [CW-1:0]     fifo_count;

    assign imm_type      = imm_type_e'(imm_type_in);
    assign in_ready_out  = (fifo_count < CW'(DEPTH));
    assign out_valid_out = (fifo_count != '0);
    assign accept        = in_valid_in && in_ready_out;
    assign pop           = out_valid_out && out_ready_in;
    assign imm_err_out   = fifo_out[32];
    assign instr_out     = fifo_out[31:0];

    // Field packing and immediate range check per format; unlisted codes use the I format.
    always_comb begin
        packed_word = {imm_in[11:0], rs1_in, funct3_in, rd_in, opcode_in};
        range_err   = !fits_signed(imm_in, 12);
        case (imm_type)
            IMM_TYPE_S: begin
                packed_word = {imm_in[11:5], rs2_in, rs1_in, funct3_in, imm_in[4:0], opcode_in};
                range_err   = !fits_signed(imm_in, 12);
            end
            IMM_TYPE_B: begin
                packed_word = {imm_in[12], imm_in[10:5], rs2_in, rs1_in, funct3_in,
                               imm_in[4:1], imm_in[11], opcode_in};
                range_err   = imm_in[0] || !fits_signed(imm_in, 13);
            end
            IMM_TYPE_U: begin
                packed_word = {imm_in[31:12], rd_in, opcode_in};
                range_err   = |imm_in[11:0];
            end
            IMM_TYPE_J: begin
                packed_word = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], rd_in, opcode_in};
                range_err   = imm_in[0] || !fits_signed(imm_in, 21);
            end
            IMM_TYPE_CSR: begin
                packed_word = {funct7_in, rs2_in, imm_in[4:0], funct3_in, rd_in, opcode_in};
                range_err   = |imm_in[31:5];
            end
            default: begin
                packed_word = {imm_in[11:0], rs1_in, funct3_in, rd_in, opcode_in};
                range_err   = !fits_signed(imm_in, 12);
            end
        endcase
    end

    instr_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (accept),
        .push_data ({range_err, packed_word}),
        .pop       (out_ready_in),
        .pop_data  (fifo_out),
        .count     (fifo_count)
    );

    // Sticky error flag: a new error on accept takes priority over clear.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            err_sticky_out <= 1'b0;
        end else if (accept && range_err) begin
            err_sticky_out <= 1'b1;
        end else if (clr_in) begin
            err_sticky_out <= 1'b0;
        end
    end

    // Count of words handed downstream, wrapping at 2^CNT_W.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            word_count_out <= '0;
        end else if (pop) begin
            word_count_out <= word_count_out + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: fixed vectors, hand sequences for FIFO/sticky/reset
// corners, and random traffic against a decode-and-compare model.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       imm_type;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [6:0]       funct7;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instr;
    logic             imm_err;
    logic             err_sticky;
    logic             clr;
    logic [CNT_W-1:0] word_count;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .in_valid_in    (in_valid),
        .in_ready_out   (in_ready),
        .imm_type_in    (imm_type),
        .opcode_in      (opcode),
        .rd_in          (rd),
        .funct3_in      (funct3),
        .rs1_in         (rs1),
        .rs2_in         (rs2),
        .funct7_in      (funct7),
        .imm_in         (imm),
        .out_valid_out  (out_valid),
        .out_ready_in   (out_ready),
        .instr_out      (instr),
        .imm_err_out    (imm_err),
        .err_sticky_out (err_sticky),
        .clr_in         (clr),
        .word_count_out (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  t;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
    } bundle_t;

    typedef struct packed {
        bundle_t     b;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bundle_t mk(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd_v,
                                   input logic [2:0] f3, input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                                   input logic [6:0] f7, input logic [31:0] imm_v);
        bundle_t b;
        b.t = t; b.op = op; b.rd = rd_v; b.f3 = f3; b.rs1 = rs1_v; b.rs2 = rs2_v; b.f7 = f7; b.imm = imm_v;
        return b;
    endfunction

    task automatic drive(input bundle_t b);
        imm_type = b.t; opcode = b.op; rd = b.rd; funct3 = b.f3;
        rs1 = b.rs1; rs2 = b.rs2; funct7 = b.f7; imm = b.imm;
    endtask

    function automatic bit is_i(input logic [2:0] t);
        return (t == IMM_TYPE_I) || (t == IMM_TYPE_I2) || (t == IMM_TYPE_I3);
    endfunction

    // Signed value of v reduced modulo 2^bits into [-2^(bits-1), 2^(bits-1)).
    function automatic int wrap(input longint v, input int bits);
        longint m;
        longint r;
        m = 64'sd1 <<< bits;
        r = v % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return int'(r);
    endfunction

    // Whether the immediate lies outside what the format can express.
    function automatic bit exp_err(input bundle_t b);
        int s;
        s = int'(b.imm);
        case (b.t)
            IMM_TYPE_S:   return (s < -2048) || (s > 2047);
            IMM_TYPE_B:   return (s % 2 != 0) || (s < -4096) || (s > 4095);
            IMM_TYPE_U:   return (b.imm % 4096) != 0;
            IMM_TYPE_J:   return (s % 2 != 0) || (s < -1048576) || (s > 1048575);
            IMM_TYPE_CSR: return b.imm > 31;
            default:      return (s < -2048) || (s > 2047);
        endcase
    endfunction

    // Immediate a decoder should recover after truncation to the format.
    function automatic int exp_imm(input bundle_t b);
        int s;
        int r;
        s = int'(b.imm);
        case (b.t)
            IMM_TYPE_B: begin
                r = wrap(longint'(s), 13);
                if (r % 2 != 0) r = r - 1;
                return r;
            end
            IMM_TYPE_U:   return int'(b.imm - (b.imm % 4096));
            IMM_TYPE_J: begin
                r = wrap(longint'(s), 21);
                if (r % 2 != 0) r = r - 1;
                return r;
            end
            IMM_TYPE_CSR: return int'(b.imm % 32);
            default:      return wrap(longint'(s), 12);
        endcase
    endfunction

    // Standard RV32I immediate decoder (CSR: zimm from the rs1 slot).
    function automatic logic [31:0] dec_imm(input logic [2:0] t, input logic [31:0] w);
        case (t)
            IMM_TYPE_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            IMM_TYPE_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            IMM_TYPE_U:   return {w[31:12], 12'b0};
            IMM_TYPE_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            IMM_TYPE_CSR: return {27'b0, w[19:15]};
            default:      return {{20{w[31]}}, w[31:20]};
        endcase
    endfunction

    task automatic check_word(input bundle_t b, input logic [31:0] w, input logic e);
        check("opcode", 32'(w[6:0]), 32'(b.op));
        if (b.t != IMM_TYPE_S && b.t != IMM_TYPE_B) check("rd", 32'(w[11:7]), 32'(b.rd));
        if (b.t != IMM_TYPE_U && b.t != IMM_TYPE_J) check("funct3", 32'(w[14:12]), 32'(b.f3));
        if (is_i(b.t) || b.t == IMM_TYPE_S || b.t == IMM_TYPE_B) check("rs1", 32'(w[19:15]), 32'(b.rs1));
        if (b.t == IMM_TYPE_S || b.t == IMM_TYPE_B) check("rs2", 32'(w[24:20]), 32'(b.rs2));
        if (b.t == IMM_TYPE_CSR) check("csr_addr", 32'(w[31:20]), 32'({b.f7, b.rs2}));
        check("imm_roundtrip", dec_imm(b.t, w), 32'(exp_imm(b)));
        check("imm_err", 32'(e), 32'(exp_err(b)));
    endtask

    function automatic bundle_t rand_bundle();
        bundle_t b;
        int s;
        b = mk(3'($urandom), 7'($urandom), 5'($urandom), 3'($urandom),
               5'($urandom), 5'($urandom), 7'($urandom), $urandom);
        if ($urandom_range(0, 9) < 7) begin
            case (b.t)
                IMM_TYPE_S:   s = $urandom_range(0, 4095) - 2048;
                IMM_TYPE_B:   s = ($urandom_range(0, 4095) - 2048) * 2;
                IMM_TYPE_U:   s = int'($urandom & 32'hFFFF_F000);
                IMM_TYPE_J:   s = ($urandom_range(0, 1048575) - 524288) * 2;
                IMM_TYPE_CSR: s = $urandom_range(0, 31);
                default:      s = $urandom_range(0, 4095) - 2048;
            endcase
            b.imm = 32'(s);
        end
        return b;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] small_i(input int v);
        return (32'(v) << 20) | 32'h13;
    endfunction

    vec_t         vq[$];
    bundle_t      sb[$];
    bundle_t      b;
    bit           acc;
    bit           pop;
    logic         sticky_m;
    logic [15:0]  wc_m;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
        drive(mk(3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0));

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_instr", instr, 32'd0);
        check("rst_imm_err", 32'(imm_err), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Fixed vectors: {type, opcode, rd, funct3, rs1, rs2, funct7, imm}, expected word, expected error
        vq.push_back('{mk(3'd0, 7'h13, 5'd1,  3'd0, 5'd2,  5'd0,  7'h00, 32'hFFFF_F800), 32'h8001_0093, 1'b0});
        vq.push_back('{mk(3'd0, 7'h13, 5'd0,  3'd0, 5'd0,  5'd31, 7'h00, 32'h0000_07FF), 32'h7FF0_0013, 1'b0});
        vq.push_back('{mk(3'd0, 7'h13, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h0000_0800), 32'h8000_0013, 1'b1});
        vq.push_back('{mk(3'd2, 7'h23, 5'd31, 3'd2, 5'd2,  5'd5,  7'h7F, 32'h0000_0008), 32'h0051_2423, 1'b0});
        vq.push_back('{mk(3'd3, 7'h63, 5'd31, 3'd0, 5'd0,  5'd0,  7'h00, 32'h0000_0003), 32'h0000_0163, 1'b1});
        vq.push_back('{mk(3'd3, 7'h63, 5'd0,  3'd1, 5'd0,  5'd0,  7'h00, 32'hFFFF_FFFC), 32'hFE00_1EE3, 1'b0});
        vq.push_back('{mk(3'd4, 7'h37, 5'd5,  3'd7, 5'd31, 5'd0,  7'h00, 32'h1234_5000), 32'h1234_52B7, 1'b0});
        vq.push_back('{mk(3'd4, 7'h37, 5'd5,  3'd0, 5'd0,  5'd0,  7'h00, 32'h1234_5001), 32'h1234_52B7, 1'b1});
        vq.push_back('{mk(3'd5, 7'h6F, 5'd1,  3'd5, 5'd0,  5'd0,  7'h00, 32'h0000_0008), 32'h0080_00EF, 1'b0});
        vq.push_back('{mk(3'd5, 7'h6F, 5'd1,  3'd0, 5'd0,  5'd0,  7'h00, 32'h0010_0000), 32'h8000_00EF, 1'b1});
        vq.push_back('{mk(3'd5, 7'h6F, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'hFFFF_FFF8), 32'hFF9F_F06F, 1'b0});
        vq.push_back('{mk(3'd6, 7'h73, 5'd3,  3'd5, 5'd31, 5'd0,  7'h18, 32'h0000_0005), 32'h3002_D1F3, 1'b0});
        vq.push_back('{mk(3'd6, 7'h73, 5'd3,  3'd5, 5'd0,  5'd0,  7'h18, 32'h0000_0020), 32'h3000_51F3, 1'b1});
        vq.push_back('{mk(3'd7, 7'h13, 5'd0,  3'd0, 5'd1,  5'd0,  7'h00, 32'hFFFF_FFFF), 32'hFFF0_8013, 1'b0});
        vq.push_back('{mk(3'd1, 7'h03, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'hFFFF_F7FF), 32'h7FF0_0003, 1'b1});

        out_ready = 1'b1;
        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].b);
            in_valid = 1'b1;
            check("vec_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("vec_out_valid", 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_instr", i), instr, vq[i].instr);
            check($sformatf("vec%0d_err", i), 32'(imm_err), 32'(vq[i].err));
        end
        @(posedge clk); #1;
        check("vec_word_count", 32'(word_count), 32'(vq.size()));
        check("vec_sticky", 32'(err_sticky), 32'd1);
        check("vec_drained", 32'(out_valid), 32'd0);

        // Sticky error: set, set-with-clear keeps it set, lone clear drops it
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        drive(mk(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h3));
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("stk_imm_err", 32'(imm_err), 32'd1);
        check("stk_set", 32'(err_sticky), 32'd1);
        @(negedge clk);
        drive(mk(3'd0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h1000));
        in_valid = 1'b1; clr = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; clr = 1'b0;
        check("stk_set_wins", 32'(err_sticky), 32'd1);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("stk_cleared", 32'(err_sticky), 32'd0);

        // Full FIFO: third bundle waits until a slot frees, order preserved
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(mk(3'd0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'(k + 1)));
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        check("full_ready_low", 32'(in_ready), 32'd0);
        check("full_head", instr, small_i(1));
        @(negedge clk);
        drive(mk(3'd0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'd3));
        @(posedge clk); #1;
        check("full_stall_ready", 32'(in_ready), 32'd0);
        check("full_head_stable", instr, small_i(1));
        check("full_no_pop", 32'(word_count), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("full_pop_frees", 32'(in_ready), 32'd1);
        check("full_word2", instr, small_i(2));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_word3", instr, small_i(3));
        @(posedge clk); #1;
        check("full_empty", 32'(out_valid), 32'd0);
        check("full_hold_last", instr, small_i(3));
        check("full_count3", 32'(word_count), 32'd3);

        // Back-to-back push/pop: one word per cycle, occupancy stays at one
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(mk(3'd0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'(16 + k)));
            in_valid = 1'b1;
            check("b2b_ready", 32'(in_ready), 32'd1);
            if (k > 0) begin
                check("b2b_valid", 32'(out_valid), 32'd1);
                check("b2b_word", instr, small_i(16 + k - 1));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_last", instr, small_i(21));
        @(posedge clk); #1;
        check("b2b_empty", 32'(out_valid), 32'd0);
        check("b2b_count", 32'(word_count), 32'd6);

        // Asynchronous reset with two words queued
        do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        drive(mk(3'd0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'd5));
        in_valid = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        drive(mk(3'd0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h1000));
        @(negedge clk);
        out_ready = 1'b0;
        drive(mk(3'd0, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'd6));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 32'd0);
        check("pre_rst_count", 32'(word_count), 32'd1);
        check("pre_rst_sticky", 32'(err_sticky), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(word_count), 32'd0);
        check("arst_sticky", 32'(err_sticky), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_instr", instr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(out_valid), 32'd0);

        // Random traffic against the scoreboard model
        do_reset();
        sticky_m = 1'b0;
        wc_m = '0;
        sb.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            check("rnd_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
            check("rnd_valid", 32'(out_valid), 32'(sb.size() > 0));
            check("rnd_sticky", 32'(err_sticky), 32'(sticky_m));
            check("rnd_count", 32'(word_count), 32'(wc_m));
            b = rand_bundle();
            drive(b);
            if (cyc < 3980) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ((cyc / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            clr = ($urandom_range(0, 15) == 0);
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                if (sb.size() > 0) begin
                    check_word(sb[0], instr, imm_err);
                    void'(sb.pop_front());
                end
                wc_m = wc_m + 16'd1;
            end
            if (acc) begin
                sb.push_back(b);
            end
            if (acc && exp_err(b)) sticky_m = 1'b1;
            else if (clr) sticky_m = 1'b0;
        end
        @(negedge clk);
        check("rnd_drained", 32'(out_valid), 32'd0);
        check("rnd_model_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
